// File: rtl/simd_seq_ctrl.sv
// SIMD PE-array sequencer: accepts one vector instruction, walks the register
// file row by row issuing reads, op select and a write-back one cycle later.
module simd_seq_ctrl #(
    parameter int unsigned NUM_PE       = 8,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned LEN_WIDTH    = 8,
    parameter int unsigned OP_SEL_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [OP_SEL_WIDTH-1:0] instr_op,
    input  logic [ADDR_WIDTH-1:0]   instr_src_a,
    input  logic [ADDR_WIDTH-1:0]   instr_src_b,
    input  logic [ADDR_WIDTH-1:0]   instr_dst,
    input  logic [LEN_WIDTH-1:0]    instr_len,
    input  logic                    stall,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr_a,
    output logic [ADDR_WIDTH-1:0]   rd_addr_b,
    output logic [OP_SEL_WIDTH-1:0] pe_op,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic                    busy,
    output logic                    done
);

    // Lane count only describes the datapath width; reject a degenerate array.
    if (NUM_PE == 0) begin : g_bad_num_pe
        $error("simd_seq_ctrl: NUM_PE must be nonzero");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic                  issue;
    logic                  last_row;

    // Stall must gate the read in the same cycle the register-file port is busy.
    assign issue    = (state == RUN) && !stall;
    assign rd_en    = issue;
    assign last_row = (cnt == (len_q - LEN_WIDTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            len_q       <= '0;
            dst_q       <= '0;
            rd_addr_a   <= '0;
            rd_addr_b   <= '0;
            pe_op       <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            instr_ready <= 1'b1;
        end else begin
            wr_en <= issue;
            done  <= 1'b0;
            // Write-back trails the read by the register file's read latency.
            if (issue) begin
                wr_addr <= dst_q + ADDR_WIDTH'(cnt);
            end
            unique case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        pe_op       <= instr_op;
                        rd_addr_a   <= instr_src_a;
                        rd_addr_b   <= instr_src_b;
                        dst_q       <= instr_dst;
                        len_q       <= instr_len;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        instr_ready <= 1'b0;
                        if (instr_len != '0) begin
                            state <= RUN;
                        end else begin
                            state <= DRAIN;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!stall) begin
                        cnt       <= cnt + LEN_WIDTH'(1);
                        rd_addr_a <= rd_addr_a + ADDR_WIDTH'(1);
                        rd_addr_b <= rd_addr_b + ADDR_WIDTH'(1);
                        if (last_row) begin
                            state <= DRAIN;
                            done  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simd_seq_ctrl.sv
// Bench for simd_seq_ctrl: directed vector table, hand-written corner sequences
// and randomized traffic checked every cycle against a row-walk reference model.
module tb_simd_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [1:0] instr_op = '0;
    logic [7:0] instr_src_a = '0;
    logic [7:0] instr_src_b = '0;
    logic [7:0] instr_dst = '0;
    logic [7:0] instr_len = '0;
    logic       stall = 1'b0;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [1:0] pe_op;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    simd_seq_ctrl #(
        .NUM_PE(8), .ADDR_WIDTH(8), .LEN_WIDTH(8), .OP_SEL_WIDTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_src_a(instr_src_a), .instr_src_b(instr_src_b),
        .instr_dst(instr_dst), .instr_len(instr_len), .stall(stall),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .pe_op(pe_op), .wr_en(wr_en), .wr_addr(wr_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an instruction is a list of rows 0..len-1; each unstalled
    // cycle consumes the next row, its write lands one cycle later, then one
    // completion cycle precedes the return to idle.
    bit m_idle = 1'b1, m_run = 1'b0, m_drain = 1'b0, m_wr = 1'b0;
    int m_k = 0, m_len = 0, m_sa = 0, m_sb = 0, m_dst = 0, m_op = 0, m_wra = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1; m_run <= 1'b0; m_drain <= 1'b0; m_wr <= 1'b0;
            m_k <= 0; m_len <= 0; m_sa <= 0; m_sb <= 0; m_dst <= 0;
            m_op <= 0; m_wra <= 0;
        end else if (m_run) begin
            m_wr <= !stall;
            if (!stall) begin
                m_wra <= (m_dst + m_k) % 256;
                m_k   <= m_k + 1;
                if (m_k + 1 == m_len) begin
                    m_run   <= 1'b0;
                    m_drain <= 1'b1;
                end
            end
        end else if (m_drain) begin
            m_wr    <= 1'b0;
            m_drain <= 1'b0;
            m_idle  <= 1'b1;
        end else begin
            m_wr <= 1'b0;
            if (instr_valid) begin
                m_op  <= int'(instr_op);
                m_sa  <= int'(instr_src_a);
                m_sb  <= int'(instr_src_b);
                m_dst <= int'(instr_dst);
                m_len <= int'(instr_len);
                m_k   <= 0;
                m_idle <= 1'b0;
                if (instr_len == 8'd0) m_drain <= 1'b1;
                else                   m_run   <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("instr_ready", 32'(instr_ready), 32'(m_idle));
        chk("busy", 32'(busy), 32'(!m_idle));
        chk("done", 32'(done), 32'(m_drain));
        chk("rd_en", 32'(rd_en), 32'(m_run && !stall));
        chk("rd_addr_a", 32'(rd_addr_a), 32'((m_sa + m_k) % 256));
        chk("rd_addr_b", 32'(rd_addr_b), 32'((m_sb + m_k) % 256));
        chk("pe_op", 32'(pe_op), 32'(m_op));
        chk("wr_en", 32'(wr_en), 32'(m_wr));
        chk("wr_addr", 32'(wr_addr), 32'(m_wra));
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  sa, sb, dst, len;
        logic [15:0] stall_mask;   // bit n = stall during cycle Tn
        int          exp_done;     // cycle index of done, relative to T0
        int          exp_rds, exp_wrs;
        logic [7:0]  exp_first_rda, exp_last_rda, exp_first_wra, exp_last_wra;
    } vec_t;

    vec_t tab[4];

    // Entered #1 after a rising edge; leaves at the same phase.
    task automatic run_vec(input vec_t v, input string tag);
        int cyc = 1, done_cyc = -1, nrd = 0, nwr = 0;
        logic [7:0] f_rda = '0, l_rda = '0, f_wra = '0, l_wra = '0;
        instr_op = v.op; instr_src_a = v.sa; instr_src_b = v.sb;
        instr_dst = v.dst; instr_len = v.len; instr_valid = 1'b1; stall = 1'b0;
        @(negedge clk);
        chk({tag, "_accept_ready"}, 32'(instr_ready), 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        while (done_cyc < 0 && cyc < 40) begin
            stall = (cyc < 16) ? v.stall_mask[cyc] : 1'b0;
            @(negedge clk);
            if (rd_en) begin
                chk({tag, "_rd_seq"}, 32'(rd_addr_a), 32'(8'(v.sa + 8'(nrd))));
                if (nrd == 0) f_rda = rd_addr_a;
                l_rda = rd_addr_a;
                nrd++;
            end
            if (wr_en) begin
                if (nwr == 0) f_wra = wr_addr;
                l_wra = wr_addr;
                nwr++;
            end
            if (done) begin
                done_cyc = cyc;
                chk({tag, "_ready_in_done"}, 32'(instr_ready), 32'd0);
                chk({tag, "_op_in_done"}, 32'(pe_op), 32'(v.op));
            end
            @(posedge clk); #1;
            cyc++;
        end
        stall = 1'b0;
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
        chk({tag, "_n_reads"}, 32'(nrd), 32'(v.exp_rds));
        chk({tag, "_n_writes"}, 32'(nwr), 32'(v.exp_wrs));
        if (v.exp_rds > 0) begin
            chk({tag, "_first_rda"}, 32'(f_rda), 32'(v.exp_first_rda));
            chk({tag, "_last_rda"}, 32'(l_rda), 32'(v.exp_last_rda));
            chk({tag, "_first_wra"}, 32'(f_wra), 32'(v.exp_first_wra));
            chk({tag, "_last_wra"}, 32'(l_wra), 32'(v.exp_last_wra));
        end
        @(negedge clk);
        chk({tag, "_ready_after"}, 32'(instr_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc2;
        tab[0] = '{op: 2'b01, sa: 8'h10, sb: 8'h20, dst: 8'h30, len: 8'd3, stall_mask: 16'h0000,
                   exp_done: 4, exp_rds: 3, exp_wrs: 3, exp_first_rda: 8'h10, exp_last_rda: 8'h12,
                   exp_first_wra: 8'h30, exp_last_wra: 8'h32};
        tab[1] = '{op: 2'b11, sa: 8'h44, sb: 8'h55, dst: 8'h66, len: 8'd0, stall_mask: 16'h0000,
                   exp_done: 1, exp_rds: 0, exp_wrs: 0, exp_first_rda: 8'h00, exp_last_rda: 8'h00,
                   exp_first_wra: 8'h00, exp_last_wra: 8'h00};
        tab[2] = '{op: 2'b10, sa: 8'hFE, sb: 8'h40, dst: 8'hFF, len: 8'd3, stall_mask: 16'h0000,
                   exp_done: 4, exp_rds: 3, exp_wrs: 3, exp_first_rda: 8'hFE, exp_last_rda: 8'h00,
                   exp_first_wra: 8'hFF, exp_last_wra: 8'h01};
        tab[3] = '{op: 2'b01, sa: 8'h50, sb: 8'h60, dst: 8'h70, len: 8'd4, stall_mask: 16'h000C,
                   exp_done: 7, exp_rds: 4, exp_wrs: 4, exp_first_rda: 8'h50, exp_last_rda: 8'h53,
                   exp_first_wra: 8'h70, exp_last_wra: 8'h73};

        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) run_vec(tab[i], $sformatf("vec%0d", i));

        // Back-to-back with valid held high: second accepted in the first's idle-return cycle.
        acc2 = -1;
        instr_op = 2'b01; instr_src_a = 8'h00; instr_src_b = 8'h08;
        instr_dst = 8'h10; instr_len = 8'd2; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_op = 2'b11; instr_src_a = 8'h20; instr_src_b = 8'h28;
        instr_dst = 8'h30; instr_len = 8'd1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (instr_ready && instr_valid && acc2 < 0) acc2 = cyc;
            if (cyc == 3) chk("b2b_op_last_wr", 32'(pe_op), 32'd1);
            if (cyc == 4) chk("b2b_op_before", 32'(pe_op), 32'd1);
            if (cyc == 5) chk("b2b_op_after", 32'(pe_op), 32'd3);
            @(posedge clk); #1;
            if (acc2 >= 0) instr_valid = 1'b0;
        end
        chk("b2b_accept_cycle", 32'(acc2), 32'd4);

        // Reset during T2 of a len=5 instruction.
        instr_op = 2'b10; instr_src_a = 8'h80; instr_src_b = 8'h90;
        instr_dst = 8'hA0; instr_len = 8'd5; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_ready", 32'(instr_ready), 32'd1);
        chk("rstmid_rd_en", 32'(rd_en), 32'd0);
        chk("rstmid_wr_en", 32'(wr_en), 32'd0);
        chk("rstmid_wr_addr", 32'(wr_addr), 32'd0);
        chk("rstmid_rd_addr_a", 32'(rd_addr_a), 32'd0);
        chk("rstmid_pe_op", 32'(pe_op), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rstmid_no_wr", 32'(wr_en), 32'd0);
            chk("rstmid_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        run_vec(tab[0], "post_rst");

        // Random traffic; the per-cycle model comparison does the checking.
        for (int i = 0; i < 800; i++) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr_op    = 2'($urandom_range(0, 3));
            instr_src_a = 8'($urandom_range(0, 255));
            instr_src_b = 8'($urandom_range(0, 255));
            instr_dst   = 8'($urandom_range(0, 255));
            instr_len   = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(8, 30))
                                                       : 8'($urandom_range(0, 5));
            stall       = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        stall = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simd_seq_ctrl.md
# simd_seq_ctrl

Sequencer for the SIMD PE array. It accepts one vector instruction at a time over a valid/ready handshake. It then walks the vector register file row by row (one row = NUM_PE lanes): it issues source reads, drives the array-wide op select, and issues the matching write-back one cycle later. It sits between the instruction front-end and the register-file/PE-array datapath. It is the only agent driving `pe_op` and the register-file ports.

## Interface
- NUM_PE, 8, lanes per row (informational; not used in arithmetic here)
- ADDR_WIDTH, 8, register-file row address width
- LEN_WIDTH, 8, instruction length field width (rows)
- OP_SEL_WIDTH, 2, PE op select width (00 pass b, 01 add, 10 sub, 11 mul)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept
- instr_op  in  OP_SEL_WIDTH  PE operation
- instr_src_a / instr_src_b  in  ADDR_WIDTH  first source row of operand a / b
- instr_dst  in  ADDR_WIDTH  first destination row
- instr_len  in  LEN_WIDTH  number of rows; 0 = no-op
- stall  in  1  hold read issue (register-file port busy)
- rd_en  out  1  read both source rows this cycle
- rd_addr_a / rd_addr_b  out  ADDR_WIDTH  source row addresses
- pe_op  out  OP_SEL_WIDTH  op select to every PE
- wr_en  out  1  write PE results this cycle
- wr_addr  out  ADDR_WIDTH  destination row
- busy  out  1  instruction in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DRAIN.
- `instr_ready` = (state == IDLE). `busy` = (state != IDLE).
- IDLE, on `instr_valid && instr_ready`:
  - latch op, src_a, src_b, dst and len; clear row counter `cnt`.
  - go to RUN if len != 0, else go to DRAIN (no reads, no writes).
- RUN, each cycle with `stall` = 0:
  - `rd_en` = 1, `rd_addr_a` = src_a + cnt, `rd_addr_b` = src_b + cnt; then cnt++.
  - after issuing row cnt == len-1, go to DRAIN.
- RUN with `stall` = 1: `rd_en` = 0; cnt and addresses hold; state holds.
- DRAIN: `rd_en` = 0; `done` = 1 for exactly this cycle; next state IDLE.
- Write-back is registered one cycle behind read:
  - `wr_en` <= rd_en.
  - `wr_addr` <= dst + (row just read).
  - This matches the register file's 1-cycle synchronous read followed by the combinational PE stage.
- `pe_op` = latched op, driven from acceptance until the cycle after the final `wr_en`. In IDLE it holds its last value.
- Address arithmetic is modulo 2^ADDR_WIDTH; rows wrap from 2^ADDR_WIDTH-1 to 0 silently.
- No hazard detection. Row k is read before it is written, so in-place operation (dst == src) is correct. Other overlaps are the front-end's responsibility.
- `stall` is ignored in IDLE and DRAIN. A read already issued always completes its write-back the next cycle, regardless of `stall`.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE, `instr_ready` = 1, cnt = 0.
  - `rd_en`, `wr_en`, `busy`, `done` = 0.
  - `rd_addr_a`, `rd_addr_b`, `wr_addr`, `pe_op` = 0.
- Reset mid-instruction aborts it immediately: no further `wr_en`, no `done`.
- Accept at edge T0, len = L ≥ 1, no stall:
  - `rd_en` high in cycles T1..TL.
  - `wr_en` high in cycles T2..TL+1.
  - DRAIN in cycle TL+1, so `done` coincides with the last `wr_en`.
  - IDLE and `instr_ready` in TL+2.
  - Total latency from acceptance to `done` = L+1 cycles.
- L = 0: `done` in T1, `instr_ready` again in T2.
- Each stall cycle in RUN adds exactly one cycle to the latency.
- Back-to-back throughput: one instruction per L+2 cycles.

## Test plan
- Reset, then add: op=01, src_a=0x10, src_b=0x20, dst=0x30, len=3.
  - `rd_addr_a` = 10,11,12 and `rd_addr_b` = 20,21,22 in T1–T3.
  - `wr_en` with `wr_addr` = 30,31,32 in T2–T4.
  - `done` in T4 only; `pe_op` = 01 throughout.
- len=0, op=11 -> no `rd_en` or `wr_en`; `done` in T1; `instr_ready` = 0 in T1 and 1 in T2.
- Wrap-around: src_a=0xFE, dst=0xFF, len=3, op=10.
  - `rd_addr_a` = FE,FF,00.
  - `wr_addr` = FF,00,01.
- Stall: len=4, `stall` high during T2 and T3.
  - `rd_en` in T1, T4, T5, T6; `wr_en` in T2, T5, T6, T7.
  - `done` in T7; no row skipped or repeated.
- Back-to-back instructions with `instr_valid` held high.
  - Second instruction accepted at the edge ending the first's IDLE-return cycle.
  - `pe_op` switches only after the first's final `wr_en`.
- Drop rst_n in T2 of a len=5 instruction.
  - All outputs reset asynchronously; no later `wr_en` or `done`.
  - After release, `instr_ready` = 1 and a new instruction runs correctly.
